// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Holds the memory-type codes, the FSM state encoding, the port-index
// constants and the round-robin pick helper.
package memory_port_arbiter_pkg;

    localparam int unsigned MEM_TYPE_W = 2;
    localparam int unsigned NUM_PORTS  = 2;

    // Memory-type codes placed on mem_type.
    localparam logic [MEM_TYPE_W-1:0] MEM_RAM = 2'd0;
    localparam logic [MEM_TYPE_W-1:0] MEM_ROM = 2'd1;
    localparam logic [MEM_TYPE_W-1:0] MEM_IO  = 2'd2;
    localparam logic [MEM_TYPE_W-1:0] MEM_EXT = 2'd3;

    // Bit positions of each requester in the req/grant vectors.
    localparam bit PORT_IF = 1'b0;
    localparam bit PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // Round-robin pick: on a tie the port not granted last wins, a sole
    // requester always wins, no request yields no grant.
    function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                     input logic                 last_was_d);
        logic [NUM_PORTS-1:0] g;
        g = req;
        if (&req) begin
            g = '0;
            if (last_was_d) g[PORT_IF] = 1'b1;
            else            g[PORT_D]  = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals.
// slave  : arbiter side (takes requests, drives acks/rdata and the memory bus)
// master : environment side (requesters plus memory model)
interface memory_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TYPE_W = 2
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    // Data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [TYPE_W-1:0] d_type;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    // Memory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_input_data;
    logic              mem_read;
    logic              mem_write;
    logic [TYPE_W-1:0] mem_type;
    logic [DATA_W-1:0] mem_output_data;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_type, mem_output_data,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_address, mem_input_data, mem_read, mem_write, mem_type
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_type, mem_output_data,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_address, mem_input_data, mem_read, mem_write, mem_type
    );

endinterface

// File: rtl/memory_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst_n (async active-low), req[1:0] (bit 0 fetch, bit 1 data),
//        grant_en (strobe: the grant is taken this cycle), grant[1:0]
//        (combinational one-hot grant, zero when nothing requests).
// The last-grant register resets to fetch so the first tie goes to data.
module rr_arbiter2
    import memory_port_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 grant_en,
    output logic [NUM_PORTS-1:0] grant
);

    logic last_d_q;
    logic last_d_d;

    // Grant selection and last-grant update (only when a grant is taken).
    always_comb begin
        grant    = rr_pick(req, last_d_q);
        last_d_d = last_d_q;
        if (grant_en && (|req)) begin
            last_d_d = grant[PORT_D];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d_q <= 1'b0;
        else        last_d_q <= last_d_d;
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port.
// Ports: clock, reset_n (async active-low), bus (slave modport: fetch and
//        data request/ack/rdata plus the memory bus), busy (high outside IDLE).
// Sequence per access: IDLE (grant, operands latched) -> ACCESS for LATENCY
// cycles -> CAPTURE (read data registered) -> RESP (one-cycle ack) -> IDLE.
// LATENCY must be in 1..7 (3-bit access counter).
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TYPE_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    memory_port_arbiter_if.slave   bus,
    output logic                   busy
);

    localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                sel_d_q, sel_d_d;   // granted port is data
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_input_data_q, mem_input_data_d;
    logic [TYPE_W-1:0]   mem_type_q, mem_type_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                busy_q, busy_d;

    logic [NUM_PORTS-1:0] req_c;
    logic [NUM_PORTS-1:0] grant_c;
    logic                 idle_c;

    // Request vector in port-index order.
    always_comb begin
        req_c          = '0;
        req_c[PORT_IF] = bus.if_req;
        req_c[PORT_D]  = bus.d_req;
    end

    assign idle_c = (state_q == ST_IDLE);

    rr_arbiter2 u_rr (
        .clk      (clock),
        .rst_n    (reset_n),
        .req      (req_c),
        .grant_en (idle_c),
        .grant    (grant_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        sel_d_d          = sel_d_q;
        we_d             = we_q;
        mem_address_d    = mem_address_q;
        mem_input_data_d = mem_input_data_q;
        mem_type_d       = mem_type_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = 1'b0;             // write strobe lasts one cycle
        if_ack_d         = 1'b0;
        d_ack_d          = 1'b0;
        if_rdata_d       = if_rdata_q;
        d_rdata_d        = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                mem_read_d = 1'b0;
                cnt_d      = 3'd0;
                if (grant_c[PORT_D]) begin
                    sel_d_d          = 1'b1;
                    we_d             = bus.d_we;
                    mem_address_d    = bus.d_addr;
                    mem_input_data_d = bus.d_wdata;
                    mem_type_d       = bus.d_type;
                    mem_read_d       = ~bus.d_we;
                    mem_write_d      = bus.d_we;
                    state_d          = ST_ACCESS;
                end else if (grant_c[PORT_IF]) begin
                    sel_d_d       = 1'b0;
                    we_d          = 1'b0;
                    mem_address_d = bus.if_addr;
                    mem_type_d    = TYPE_W'(MEM_ROM);
                    mem_read_d    = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d      = 3'd0;
                    mem_read_d = 1'b0;
                    state_d    = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_CAPTURE: begin
                // Only the granted port's rdata moves, and only on a read.
                if (!we_q) begin
                    if (sel_d_q) d_rdata_d  = bus.mem_output_data;
                    else         if_rdata_d = bus.mem_output_data;
                end
                if_ack_d = ~sel_d_q;
                d_ack_d  = sel_d_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 3'd0;
            sel_d_q          <= 1'b0;
            we_q             <= 1'b0;
            mem_address_q    <= '0;
            mem_input_data_q <= '0;
            mem_type_q       <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            if_ack_q         <= 1'b0;
            d_ack_q          <= 1'b0;
            if_rdata_q       <= '0;
            d_rdata_q        <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            sel_d_q          <= sel_d_d;
            we_q             <= we_d;
            mem_address_q    <= mem_address_d;
            mem_input_data_q <= mem_input_data_d;
            mem_type_q       <= mem_type_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            if_ack_q         <= if_ack_d;
            d_ack_q          <= d_ack_d;
            if_rdata_q       <= if_rdata_d;
            d_rdata_q        <= d_rdata_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.if_ack         = if_ack_q;
    assign bus.d_ack          = d_ack_q;
    assign bus.if_rdata       = if_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_input_data = mem_input_data_q;
    assign bus.mem_type       = mem_type_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: one instance with LATENCY=1 and one
// with LATENCY=3 share the request stimulus; each has its own memory model
// that presents valid data only in the cycle after the LATENCY-th read cycle.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic        clock;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_type;
    logic [31:0] mem_val;
    logic        busy_a, busy_b;
    logic        use_b;

    int n_checks;
    int n_fail;
    logic [31:0] exp_if, exp_d;

    memory_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .TYPE_W(2)) bus_a ();
    memory_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .TYPE_W(2)) bus_b ();

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT_A), .TYPE_W(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a), .busy(busy_a));
    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT_B), .TYPE_W(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b), .busy(busy_b));

    assign bus_a.if_req  = if_req;  assign bus_b.if_req  = if_req;
    assign bus_a.if_addr = if_addr; assign bus_b.if_addr = if_addr;
    assign bus_a.d_req   = d_req;   assign bus_b.d_req   = d_req;
    assign bus_a.d_we    = d_we;    assign bus_b.d_we    = d_we;
    assign bus_a.d_addr  = d_addr;  assign bus_b.d_addr  = d_addr;
    assign bus_a.d_wdata = d_wdata; assign bus_b.d_wdata = d_wdata;
    assign bus_a.d_type  = d_type;  assign bus_b.d_type  = d_type;

    // Memory models: data valid only right after LATENCY consecutive read cycles.
    int unsigned rd_cnt_a, rd_cnt_b;
    logic        rdy_a, rdy_b;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_a <= 0; rdy_a <= 1'b0;
            rd_cnt_b <= 0; rdy_b <= 1'b0;
        end else begin
            rdy_a    <= bus_a.mem_read && (rd_cnt_a + 1 == LAT_A);
            rd_cnt_a <= bus_a.mem_read ? rd_cnt_a + 1 : 0;
            rdy_b    <= bus_b.mem_read && (rd_cnt_b + 1 == LAT_B);
            rd_cnt_b <= bus_b.mem_read ? rd_cnt_b + 1 : 0;
        end
    end
    assign bus_a.mem_output_data = rdy_a ? mem_val : 32'hBAD0_BAD0;
    assign bus_b.mem_output_data = rdy_b ? mem_val : 32'hBAD0_BAD0;

    // Observation mux for the shared transaction task.
    logic        o_if_ack, o_d_ack, o_read, o_write, o_busy;
    logic [31:0] o_addr;
    logic [1:0]  o_type;
    assign o_if_ack = use_b ? bus_b.if_ack      : bus_a.if_ack;
    assign o_d_ack  = use_b ? bus_b.d_ack       : bus_a.d_ack;
    assign o_read   = use_b ? bus_b.mem_read    : bus_a.mem_read;
    assign o_write  = use_b ? bus_b.mem_write   : bus_a.mem_write;
    assign o_addr   = use_b ? bus_b.mem_address : bus_a.mem_address;
    assign o_type   = use_b ? bus_b.mem_type    : bus_a.mem_type;
    assign o_busy   = use_b ? busy_b            : busy_a;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction from IDLE: next edge is the grant edge. Checks the
    // latched address/type, read/write strobe counts, ack port and latency,
    // and that the ack lasts one cycle before returning to IDLE.
    task automatic txn(input string tag, input bit exp_d_port, input logic [31:0] exp_addr,
                       input logic [1:0] exp_type, input bit exp_wr, input bit drop, input int lat);
        int rd_n, wr_n, ack_at;
        rd_n = 0; wr_n = 0; ack_at = 0;
        for (int c = 1; c <= lat + 4 && ack_at == 0; c++) begin
            step();
            if (c == 1) begin
                check({tag, "_type"}, 32'(o_type), 32'(exp_type));
                if (drop) begin
                    if_req  = 1'b0;
                    d_req   = 1'b0;
                    if_addr = 32'hFFFF_FFF0;
                    d_addr  = 32'hFFFF_FFF4;
                end
            end
            check({tag, "_addr"}, o_addr, exp_addr);
            check({tag, "_ack_overlap"}, 32'(o_if_ack & o_d_ack), 32'd0);
            rd_n += int'(o_read);
            wr_n += int'(o_write);
            if (o_if_ack || o_d_ack) begin
                ack_at = c;
                check({tag, "_ack_port"}, 32'({o_d_ack, o_if_ack}), exp_d_port ? 32'd2 : 32'd1);
            end
        end
        check({tag, "_ack_latency"}, 32'(ack_at), 32'(lat + 2));
        check({tag, "_read_cycles"}, 32'(rd_n), exp_wr ? 32'd0 : 32'(lat));
        check({tag, "_write_cycles"}, 32'(wr_n), exp_wr ? 32'd1 : 32'd0);
        step();
        check({tag, "_ack_drop"}, 32'(o_if_ack | o_d_ack), 32'd0);
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; use_b = 1'b0;
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_type = '0; mem_val = '0;
        exp_if = '0; exp_d = '0;

        // Reset state
        repeat (3) step();
        check("rst_busy",      32'(busy_a), 32'd0);
        check("rst_mem_read",  32'(bus_a.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus_a.mem_write), 32'd0);
        check("rst_acks",      32'({bus_a.d_ack, bus_a.if_ack}), 32'd0);
        check("rst_mem_addr",  bus_a.mem_address, 32'd0);
        check("rst_mem_wdata", bus_a.mem_input_data, 32'd0);
        check("rst_mem_type",  32'(bus_a.mem_type), 32'd0);
        check("rst_if_rdata",  bus_a.if_rdata, 32'd0);
        check("rst_d_rdata",   bus_a.d_rdata, 32'd0);
        check("rst_busy_b",    32'(busy_b), 32'd0);
        reset_n = 1'b1;
        step();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h10; mem_val = 32'hDEAD_BEEF;
        txn("fetch", 1'b0, 32'h10, MEM_ROM, 1'b0, 1'b0, LAT_A);
        if_req = 1'b0;
        exp_if = 32'hDEAD_BEEF;
        check("fetch_if_rdata", bus_a.if_rdata, exp_if);
        check("fetch_d_rdata",  bus_a.d_rdata, exp_d);

        // Both requesting: data, fetch, data, fetch
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_type = MEM_IO;
        for (int k = 0; k < 4; k++) begin
            mem_val = 32'h1000_0000 + 32'(k);
            if (k % 2 == 0) begin
                txn("rr_data", 1'b1, 32'h80, MEM_IO, 1'b0, 1'b0, LAT_A);
                exp_d = mem_val;
            end else begin
                txn("rr_fetch", 1'b0, 32'h40, MEM_ROM, 1'b0, 1'b0, LAT_A);
                exp_if = mem_val;
            end
            check("rr_if_rdata", bus_a.if_rdata, exp_if);
            check("rr_d_rdata",  bus_a.d_rdata, exp_d);
        end
        if_req = 1'b0; d_req = 1'b0;

        // Data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A5A_5A5A;
        d_type = MEM_RAM; mem_val = 32'h7777_7777;
        txn("write", 1'b1, 32'h20, MEM_RAM, 1'b1, 1'b0, LAT_A);
        d_req = 1'b0; d_we = 1'b0;
        check("write_wdata",   bus_a.mem_input_data, 32'h5A5A_5A5A);
        check("write_d_rdata", bus_a.d_rdata, exp_d);

        // Sole data requester right after a data grant still wins
        d_req = 1'b1; d_addr = 32'h24; mem_val = 32'h2468_ACE0;
        txn("sole_data", 1'b1, 32'h24, MEM_RAM, 1'b0, 1'b0, LAT_A);
        d_req = 1'b0;
        exp_d = 32'h2468_ACE0;
        check("sole_d_rdata",  bus_a.d_rdata, exp_d);
        check("sole_if_rdata", bus_a.if_rdata, exp_if);
        step();
        check("idle_addr_hold", bus_a.mem_address, 32'h24);
        check("idle_no_read",   32'(bus_a.mem_read | bus_a.mem_write), 32'd0);

        // Reset during ACCESS abandons the access
        if_req = 1'b1; if_addr = 32'h30;
        step();
        check("mid_busy", 32'(busy_a), 32'd1);
        check("mid_read", 32'(bus_a.mem_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_read", 32'(bus_a.mem_read), 32'd0);
        step();
        check("mid_rst_if_rdata", bus_a.if_rdata, 32'd0);
        check("mid_rst_d_rdata",  bus_a.d_rdata, 32'd0);
        if_req = 1'b0;
        reset_n = 1'b1;
        exp_if = '0; exp_d = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_rst_noack", 32'(bus_a.if_ack | bus_a.d_ack), 32'd0);
            check("post_rst_idle",  32'(busy_a), 32'd0);
        end

        // Fresh request; req and operands dropped after grant
        if_req = 1'b1; if_addr = 32'h50; mem_val = 32'h1357_9BDF;
        txn("fresh", 1'b0, 32'h50, MEM_ROM, 1'b0, 1'b1, LAT_A);
        if_req = 1'b0; if_addr = '0; d_addr = '0;
        exp_if = 32'h1357_9BDF;
        check("fresh_if_rdata", bus_a.if_rdata, exp_if);
        check("fresh_d_rdata",  bus_a.d_rdata, exp_d);

        // LATENCY=3 read on the second instance
        repeat (8) step();
        use_b = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_type = MEM_EXT; mem_val = 32'hCAFE_F00D;
        txn("lat3", 1'b1, 32'h44, MEM_EXT, 1'b0, 1'b0, LAT_B);
        d_req = 1'b0;
        check("lat3_d_rdata",  bus_b.d_rdata, 32'hCAFE_F00D);
        check("lat3_if_rdata", bus_b.if_rdata, 32'h1357_9BDF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, word-address width on all ports.
REQ-002 Parameter DATA_W, 32, data width on all ports.
REQ-003 Parameter LATENCY, 1, memory read latency in clock cycles; legal range 1..7.
REQ-004 Parameter TYPE_W, 2, width of the memory-type code.
REQ-005 Ports, one per line, as name direction width meaning:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch requests a read.
- if_addr  in  ADDR_W  fetch word address.
- if_ack  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data requests an access.
- d_we  in  1  data access is a write.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_type  in  TYPE_W  data memory type.
- d_ack  out  1  one-cycle completion pulse to data.
- d_rdata  out  DATA_W  data read data.
- mem_address  out  ADDR_W  to memory.
- mem_input_data  out  DATA_W  to memory.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_type  out  TYPE_W  to memory.
- mem_output_data  in  DATA_W  from memory.
- busy  out  1  high in any state except IDLE.

Function
REQ-006 The block SHALL run a four-state FSM: IDLE, ACCESS, CAPTURE, RESP.
REQ-007 In IDLE, at an edge with any req high, the block SHALL latch the winner's address, write data, write enable and type into registers and go to ACCESS; with no req it SHALL stay in IDLE.
REQ-008 When both reqs are high in IDLE, the block SHALL grant the port not granted last (round-robin); a sole requester always wins.
REQ-009 The last-grant register SHALL update only on a grant.
REQ-010 A fetch grant SHALL drive mem_type = MEM_ROM, mem_read = 1, mem_write = 0.
REQ-011 A data grant SHALL forward d_type and drive mem_read = ~d_we.
REQ-012 For a data write, mem_write SHALL be high for exactly the first ACCESS cycle only, with mem_input_data = latched d_wdata.
REQ-013 ACCESS SHALL last exactly LATENCY cycles, counted by a 3-bit counter; the block SHALL then go to CAPTURE.
REQ-014 In CAPTURE, on a read, the block SHALL register mem_output_data into the granted port's rdata; the other port's rdata is unchanged.
REQ-015 The block SHALL then go to RESP, where it pulses the granted port's ack high for exactly one cycle.
REQ-016 From RESP, the block SHALL return to IDLE unconditionally; reqs sampled in RESP are ignored.
REQ-017 Request-to-ack latency SHALL be LATENCY+2 cycles after the granting edge; throughput is one access per LATENCY+3 cycles.
REQ-018 Requesters hold req and operands until ack, then deassert or present a new request; the block latches operands at grant, so operand changes after grant have no effect.
REQ-019 A req dropped after grant SHALL NOT abort the access; ack is still pulsed.
REQ-020 if_ack and d_ack SHALL never be high in the same cycle.
REQ-021 The rdata outputs SHALL hold their value until that port's next read capture.
REQ-022 In IDLE, mem_read and mem_write SHALL be 0 and mem_address SHALL hold its last value.

Reset
REQ-023 On reset_n low, the block SHALL immediately enter IDLE and clear busy, acks, mem_read, mem_write, counter, mem_address, mem_input_data, mem_type and both rdata outputs.
REQ-024 Reset SHALL set last-grant = fetch, so the first tie goes to data.
REQ-025 Reset asserted mid-access SHALL abandon the access with no ack; a write already issued is not retracted.

Structure
REQ-026 MEM_* type codes, the FSM state encoding and the port-index constants SHALL live in the shared CPU definitions header.
REQ-027 Round-robin selection SHALL be one sub-module, rr_arbiter2, holding the last-grant register, with inputs req[1:0] and a grant-enable strobe and output grant[1:0].

Verification
REQ-028 Fetch only: if_req=1, if_addr=0x10, memory returns 0xDEADBEEF, LATENCY=1 -> if_ack at cycle 3 after grant edge, if_rdata=0xDEADBEEF, mem_type=MEM_ROM.
REQ-029 Simultaneous reqs held for 4 transactions -> grant order data, fetch, data, fetch; never two acks in one cycle.
REQ-030 Data write: d_we=1, d_addr=0x20, d_wdata=0x5A5A5A5A -> mem_write high exactly one cycle, mem_read=0, d_ack pulses, d_rdata unchanged.
REQ-031 LATENCY=3 read -> mem_read high 3 cycles, ack 5 cycles after grant edge, captured data matches.
REQ-032 reset_n low during ACCESS -> next cycle busy=0, mem_read=0, no ack; a fresh request afterwards completes normally.
